// File: rtl/midi_event_parser.sv
// rtl/midi_event_parser.sv - MIDI Note On/Off parser with running status and FWFT event queue
// The queue is a separate module so the parser stays a pure byte-level state machine.

module midi_event_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk_100mhz,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] held_q;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & ready;
  // A full queue still takes a push when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);

  assign valid = ~empty;
  assign head  = empty ? held_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_100mhz) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      held_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Remember the last visible head so the fields stay put once drained.
      if (!empty) begin
        held_q <= mem[rd_ptr[AW-1:0]];
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end
endmodule

module midi_event_parser #(
  parameter bit         FILTER_EN  = 1'b0,
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       event_ready,
  output logic       event_valid,
  output logic       event_note_on,
  output logic [6:0] event_note,
  output logic [6:0] event_velocity,
  output logic [3:0] event_channel,
  output logic       overflow
);
  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_D1,
    WAIT_D2,
    IGNORE
  } state_t;

  state_t      state, state_next;
  logic        byte_valid_d, acc;
  logic [7:0]  status_q, status_next;
  logic [6:0]  note_q, note_next;
  logic        push;
  logic [18:0] push_data;
  logic [18:0] head;

  assign acc = byte_valid & ~byte_valid_d;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      byte_valid_d <= 1'b1;
      state        <= WAIT_STATUS;
      status_q     <= 8'h00;
      note_q       <= 7'h00;
    end else begin
      byte_valid_d <= byte_valid;
      state        <= state_next;
      status_q     <= status_next;
      note_q       <= note_next;
    end
  end

  always_comb begin
    state_next  = state;
    status_next = status_q;
    note_next   = note_q;
    push        = 1'b0;
    push_data   = '0;
    if (acc) begin
      if (byte_in[7]) begin
        // F8-FF realtime bytes fall through every branch and leave no trace.
        if (byte_in >= 8'hF0 && byte_in < 8'hF8) begin
          status_next = 8'h00;
          state_next  = WAIT_STATUS;
        end else if (byte_in < 8'hA0) begin
          status_next = byte_in;
          state_next  = WAIT_D1;
        end else if (byte_in < 8'hF0) begin
          status_next = byte_in;
          state_next  = IGNORE;
        end
      end else begin
        case (state)
          WAIT_D1: begin
            note_next  = byte_in[6:0];
            state_next = WAIT_D2;
          end
          WAIT_D2: begin
            push       = !FILTER_EN || (status_q[3:0] == CHANNEL);
            push_data  = {status_q[4] && (byte_in[6:0] != 7'h00), note_q,
                          byte_in[6:0], status_q[3:0]};
            state_next = WAIT_D1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  midi_event_fifo #(
    .WIDTH(19),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_100mhz(clk_100mhz),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .ready     (event_ready),
    .valid     (event_valid),
    .head      (head),
    .overflow  (overflow)
  );

  assign {event_note_on, event_note, event_velocity, event_channel} = head;
endmodule

// File: doc/midi_event_parser.md
Name: midi_event_parser

Overview:
- Sits directly downstream of the UART byte receiver and consumes its byte stream (byte value plus a level-type valid flag).
- Parses MIDI channel-voice messages with running status and emits complete Note On/Note Off events, carrying note, velocity and channel, through a small FWFT event FIFO with a valid/ready handshake.
- Feeds the synth voice/note-allocation logic.

Parameters:
- FILTER_EN, 0: 1 = only events whose channel equals CHANNEL are pushed; 0 = all channels pass.
- CHANNEL, 0: 4-bit channel number used when FILTER_EN=1.
- FIFO_DEPTH, 4: event FIFO entries. Must be a power of two, minimum 2.

Ports:
- clk_100mhz, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- byte_in, input, 8: received byte from the UART receiver.
- byte_valid, input, 1: level flag. A new byte is accepted only on its 0->1 transition.
- event_ready, input, 1: consumer accepts the head event.
- event_valid, output, 1: FIFO non-empty; head event fields are valid.
- event_note_on, output, 1: 1 = Note On, 0 = Note Off.
- event_note, output, 7: note number.
- event_velocity, output, 7: velocity.
- event_channel, output, 4: MIDI channel (low nibble of the status byte).
- overflow, output, 1: sticky flag; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset values: event_valid=0, all event fields 0, overflow=0, FIFO empty, state=WAIT_STATUS, running status cleared.
- Edge detector: register byte_valid_d, which resets to 1 so a level already high after reset is not accepted. Accept strobe acc = byte_valid & ~byte_valid_d.
- Byte classes:
  - Status: bit7=1.
  - Data: bit7=0.
  - Realtime: F8-FF.
- Realtime bytes are ignored completely: no state change, running status kept.
- Status byte handling (any state):
  - 8n -> save status, go to WAIT_D1.
  - 9n -> save status, go to WAIT_D1.
  - A0-EF -> save status, go to IGNORE.
  - F0-F7 -> clear running status, go to WAIT_STATUS.
- WAIT_STATUS: data bytes are discarded.
- IGNORE: data bytes are discarded; state held until the next status byte.
- WAIT_D1: data byte -> latch it as the note, go to WAIT_D2.
- WAIT_D2: data byte -> message complete.
  - Latch the byte as velocity.
  - Push the event if the channel passes the filter.
  - Go to WAIT_D1 (running status: further data pairs reuse the saved status).
- A status byte arriving in WAIT_D2 aborts the partial message; no event is produced.
- Event encoding:
  - 8n -> note_on=0; velocity field = received velocity.
  - 9n with velocity != 0 -> note_on=1.
  - 9n with velocity == 0 -> note_on=0, velocity=0.
- Latency: the event is pushed on the clock edge where acc is high for the second data byte. event_valid is high from the following cycle, when the FIFO was previously empty.
- FIFO: first-word-fall-through, with pointers one bit wider than log2(FIFO_DEPTH).
  - Pop when event_valid & event_ready.
  - Output fields always show the head entry.
  - Fields are don't-care while empty, but must hold their last value.
- Full + push with no pop: the event is dropped, overflow is set to 1, FIFO contents are unchanged.
- Full + push with simultaneous pop: both happen and the count stays at FIFO_DEPTH. Not an overflow.
- Empty + push: event_valid rises next cycle. A pop request while empty is ignored.
- overflow is cleared only by reset.
- Reset asserted mid-message or mid-FIFO immediately returns every register to its reset value. Partial messages and queued events are lost.

Test Plan:
- Bytes 0x90,0x3C,0x64 (event_ready=1) -> one event: note_on=1, note=0x3C, velocity=0x64, channel=0, valid for exactly 1 cycle, the cycle after the third accept.
- Running status: 0x91,0x40,0x50,0x40,0x00 -> two events: (on, 0x40, 0x50, ch1), then (off, 0x40, 0x00, ch1).
- Interleaved bytes: 0x80, 0x3C, 0xF8, 0x7F -> single event (off, 0x3C, 0x7F, ch0). Then 0xB0,0x07,0x64 -> no event.
- Level semantics: byte_valid held high for 500 cycles during one byte, and high at reset release -> byte accepted once after the 0->1 edge; nothing accepted at reset release.
- FIFO_DEPTH=4, event_ready=0, six complete note-ons -> event_valid=1, overflow=1, and the first four events drain in order once event_ready=1. Push and pop on the same cycle while full -> count stays 4, overflow unchanged.
- FILTER_EN=1, CHANNEL=2: messages on ch2 and ch3 -> only the ch2 event is emitted. Reset asserted between data bytes -> no event, and the next 0x3C data byte is ignored (WAIT_STATUS).
